// File: rtl/ext_sram_pkg.sv
// Shared types and helpers for the external asynchronous SRAM controller.
package ext_sram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int DEF_WORD_WIDTH = 32;
  localparam int DEF_BUS_WIDTH  = 16;
  localparam int BEATS          = DEF_WORD_WIDTH / DEF_BUS_WIDTH;
  localparam int LANES          = DEF_BUS_WIDTH / 8;

  // Number of byte-address bits covered by one host word.
  function automatic int byte_shift(input int word_w);
    return $clog2(word_w / 8);
  endfunction

endpackage

// File: rtl/ext_sram_ctl.sv
// Host-word to async-SRAM beat sequencer with wait states and byte masks.
// Optional macro EXT_SRAM_PIPE_EN: accept a new request in the final HOLD cycle.
module ext_sram_ctl
  import ext_sram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int WORD_WIDTH  = 32,
  parameter int BUS_WIDTH   = 16,
  parameter int SRAM_AW     = 18,
  parameter int WAIT_STATES = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    valid,
  input  logic                    rw,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [WORD_WIDTH-1:0]   wdata,
  input  logic [WORD_WIDTH/8-1:0] wmask,
  output logic                    ready,
  output logic [WORD_WIDTH-1:0]   rdata,
  output logic [SRAM_AW-1:0]      sram_addr,
  output logic [BUS_WIDTH-1:0]    sram_dq_o,
  input  logic [BUS_WIDTH-1:0]    sram_dq_i,
  output logic                    sram_dq_oe,
  output logic                    sram_ce_n,
  output logic                    sram_oe_n,
  output logic                    sram_we_n,
  output logic [BUS_WIDTH/8-1:0]  sram_be_n
);

  localparam int NBEATS = WORD_WIDTH / BUS_WIDTH;
  localparam int NLANES = BUS_WIDTH / 8;
  localparam int MW     = WORD_WIDTH / 8;
  localparam int SHIFT  = byte_shift(WORD_WIDTH);
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
`ifdef EXT_SRAM_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  state_t                  state;
  logic [BW-1:0]           beat;
  logic [3:0]              wcnt;
  logic                    rw_q;
  logic [ADDR_WIDTH-1:0]   word_q;
  logic [WORD_WIDTH-1:0]   wdata_q;
  logic [MW-1:0]           wmask_q;

  logic                    last, accept, launch, l_rw;
  logic [BW-1:0]           l_beat;
  logic [ADDR_WIDTH-1:0]   l_word;
  logic [WORD_WIDTH-1:0]   l_wdata;
  logic [MW-1:0]           l_mask;

  function automatic logic [SRAM_AW-1:0] beat_addr(input logic [ADDR_WIDTH-1:0] word,
                                                   input logic [BW-1:0] b);
    logic [ADDR_WIDTH-1:0] a;
    a = word * ADDR_WIDTH'(NBEATS) + ADDR_WIDTH'(b);
    return a[SRAM_AW-1:0];
  endfunction

  function automatic logic [BUS_WIDTH-1:0] dslice(input logic [WORD_WIDTH-1:0] d,
                                                  input logic [BW-1:0] b);
    return d[int'(b)*BUS_WIDTH +: BUS_WIDTH];
  endfunction

  function automatic logic [NLANES-1:0] mslice(input logic [MW-1:0] m,
                                               input logic [BW-1:0] b);
    return m[int'(b)*NLANES +: NLANES];
  endfunction

  // A launch either starts a fresh request or advances to the next beat.
  always_comb begin
    last    = (beat == BW'(NBEATS - 1));
    accept  = valid && ((state == IDLE) || (PIPE && state == HOLD && last));
    launch  = accept || (state == HOLD && !last);
    l_rw    = accept ? rw : rw_q;
    l_word  = accept ? (addr >> SHIFT) : word_q;
    l_beat  = accept ? '0 : BW'(beat + 1'b1);
    l_wdata = accept ? wdata : wdata_q;
    l_mask  = accept ? wmask : wmask_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      beat       <= '0;
      wcnt       <= '0;
      rw_q       <= 1'b0;
      word_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      ready      <= 1'b0;
      rdata      <= '0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= '1;
    end else begin
      ready <= 1'b0;
      if (launch) begin
        if (accept) begin
          rw_q    <= rw;
          word_q  <= addr >> SHIFT;
          wdata_q <= wdata;
          wmask_q <= wmask;
        end
        state      <= SETUP;
        beat       <= l_beat;
        sram_addr  <= beat_addr(l_word, l_beat);
        sram_dq_o  <= dslice(l_wdata, l_beat);
        sram_dq_oe <= l_rw;
        sram_be_n  <= l_rw ? ~mslice(l_mask, l_beat) : '0;
        sram_ce_n  <= 1'b0;
      end else begin
        case (state)
          SETUP: begin
            state     <= STROBE;
            wcnt      <= '0;
            sram_oe_n <= rw_q;
            // An all-zero lane mask still spends the strobe time, just without we_n.
            sram_we_n <= !(rw_q && (|mslice(wmask_q, beat)));
          end
          STROBE: begin
            if (wcnt == 4'(WAIT_STATES)) begin
              state     <= HOLD;
              sram_oe_n <= 1'b1;
              sram_we_n <= 1'b1;
              if (!rw_q) rdata[int'(beat)*BUS_WIDTH +: BUS_WIDTH] <= sram_dq_i;
              if (last) ready <= 1'b1;
            end else begin
              wcnt <= wcnt + 4'd1;
            end
          end
          HOLD: begin
            state      <= IDLE;
            sram_ce_n  <= 1'b1;
            sram_be_n  <= '1;
            sram_dq_oe <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/ext_sram_ctl.md
Name: ext_sram_ctl

Overview:
- Parametrised controller for external asynchronous SRAM; successor to the fixed 16-bit EXT_SRAM front-end.
- Accepts host word requests (default 32-bit) and splits each into BEATS = WORD_WIDTH/BUS_WIDTH bus beats.
- Configurable wait states, per-byte write masks, explicit ready handshake.
- Sits between the core memory frontend and the board SRAM pins.

Parameters:
ADDR_WIDTH, 32, host byte-address width
WORD_WIDTH, 32, host data width; integer multiple of BUS_WIDTH
BUS_WIDTH, 16, SRAM data bus width; multiple of 8
SRAM_AW, 18, SRAM address pin count
WAIT_STATES, 1, extra strobe cycles per beat (0..15)

Ports:
clk  in  1  clock; all logic on rising edge
rstn  in  1  reset; synchronous, active-low
valid  in  1  host request valid
rw  in  1  1=write, 0=read
addr  in  ADDR_WIDTH  byte address; low log2(WORD_WIDTH/8) bits ignored
wdata  in  WORD_WIDTH  write data
wmask  in  WORD_WIDTH/8  write byte enables, 1=write byte
ready  out  1  one-cycle completion pulse
rdata  out  WORD_WIDTH  read data, valid when ready=1 after a read
sram_addr  out  SRAM_AW  SRAM address
sram_dq_o  out  BUS_WIDTH  data to SRAM
sram_dq_i  in  BUS_WIDTH  data from SRAM
sram_dq_oe  out  1  tristate enable for sram_dq_o
sram_ce_n  out  1  chip enable, active-low
sram_oe_n  out  1  output enable, active-low
sram_we_n  out  1  write enable, active-low
sram_be_n  out  BUS_WIDTH/8  byte-lane enables, active-low

Behaviour:
- Reset (rstn=0 at edge): state IDLE; ready=0, rdata=0, sram_addr=0, sram_dq_o=0, sram_dq_oe=0, ce_n/oe_n/we_n=1, be_n all 1. Reset mid-transfer aborts the transfer: strobes deassert at that edge; no ready is issued.
- States: IDLE, SETUP, STROBE, HOLD.
- IDLE: valid=1 at edge -> latch rw/addr/wdata/wmask, beat=0, go to SETUP. valid in any non-IDLE state is ignored (no queueing).
- Address: sram_addr = (addr>>log2(WORD_WIDTH/8))*BEATS + beat, truncated to SRAM_AW. Beat 0 is the least-significant BUS_WIDTH slice.
- SETUP (1 cycle):
  - ce_n=0; address stable.
  - Write: dq_o = current slice, dq_oe=1, be_n = ~mask slice.
  - Read: dq_oe=0, be_n=0.
- STROBE (WAIT_STATES+1 cycles, counted by a wait counter):
  - Read: oe_n=0.
  - Write: we_n=0 only if the mask slice is nonzero; a zero mask slice keeps we_n=1 and be_n all 1, with timing unchanged.
  - Read data: on the edge leaving STROBE, capture sram_dq_i into rdata slice [beat].
- HOLD (1 cycle):
  - oe_n/we_n=1; ce_n, address, dq_o and dq_oe held.
  - If beat<BEATS-1: beat++, go to SETUP.
  - Else: ready=1 for this cycle, go to IDLE.
- Latency: ready is high in cycle BEATS*(WAIT_STATES+3) after the accept edge. Defaults give 8.
- rdata holds its value until the next read's capture. Writes leave rdata unchanged.
- Minimum one IDLE cycle between transfers (baseline). we_n and oe_n are never low simultaneously.

Optional Feature:
EXT_SRAM_PIPE_EN
- Defined: in the final HOLD, valid=1 at the edge is accepted, and the controller goes directly to SETUP of the new request. Back-to-back throughput is BEATS*(WAIT_STATES+3) cycles per word. ready still pulses for the completing request.
- Undefined: requests are accepted only in IDLE. Throughput is BEATS*(WAIT_STATES+3)+1 cycles per word.

Decomposition:
- Package ext_sram_pkg:
  - State enum (IDLE/SETUP/STROBE/HOLD, 2 bits).
  - Localparams BEATS, LANES = BUS_WIDTH/8.
  - Function computing the byte-shift clog2 value.
- No sub-module; the wait counter and beat counter are inline in the FSM.

Test Plan:
(Defaults unless stated; SRAM behavioural model attached.)
1. Read addr 0x10; model holds 0xBEEF @8, 0xCAFE @9 -> ready at cycle 8, rdata=0xCAFEBEEF; oe_n low 2 cycles per beat; we_n stays 1.
2. Write 0x12345678, wmask=0xF, addr 0x20 -> model 0x5678 @0x10, 0x1234 @0x11; we_n low 2 cycles per beat; dq_oe high SETUP..HOLD.
3. Write 0xAAAA5555, wmask=0x4, addr 0x20 -> beat 0 we_n stays 1; beat 1 we_n low, be_n=2'b10; only byte 0xAA written @0x11 low lane.
4. rstn=0 during beat-0 STROBE of a write -> next edge ce_n/we_n=1, ready never pulses; next read after release completes in 8 cycles.
5. Build WAIT_STATES=0: read -> ready at cycle 6. valid pulsed during busy -> ignored; exactly one ready.
6. EXT_SRAM_PIPE_EN defined: valid held high for 3 reads -> ready pulses at cycles 8, 16, 24. Undefined: pulses at 8, 17, 26.
